// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single shared memory.
// Data wins by default, but instruction fetch is forced after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_wmask,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2, DONE = 2'd3} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   dcount, dcount_nxt;
  logic               grant_d_c, grant_i_c;
  logic               mem_read_nxt, mem_write_nxt, i_resp_nxt, d_resp_nxt;
  logic [15:0]        mem_address_nxt, mem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic [1:0]         mem_byte_enable_nxt;

  // Grant decision, only meaningful while idle
  always_comb begin
    grant_d_c = (state == IDLE) && (d_read || d_write) &&
                (!i_read || (32'(dcount) < STARVE_LIMIT));
    grant_i_c = (state == IDLE) && i_read && !grant_d_c;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      dcount          <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      i_rdata         <= '0;
      d_rdata         <= '0;
      i_resp          <= 1'b0;
      d_resp          <= 1'b0;
    end else begin
      state           <= state_nxt;
      dcount          <= dcount_nxt;
      mem_read        <= mem_read_nxt;
      mem_write       <= mem_write_nxt;
      mem_address     <= mem_address_nxt;
      mem_wdata       <= mem_wdata_nxt;
      mem_byte_enable <= mem_byte_enable_nxt;
      i_rdata         <= i_rdata_nxt;
      d_rdata         <= d_rdata_nxt;
      i_resp          <= i_resp_nxt;
      d_resp          <= d_resp_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d_c)      state_nxt = SERVE_D;
        else if (grant_i_c) state_nxt = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the starvation counter
  always_comb begin
    dcount_nxt          = dcount;
    mem_read_nxt        = mem_read;
    mem_write_nxt       = mem_write;
    mem_address_nxt     = mem_address;
    mem_wdata_nxt       = mem_wdata;
    mem_byte_enable_nxt = mem_byte_enable;
    i_rdata_nxt         = i_rdata;
    d_rdata_nxt         = d_rdata;
    i_resp_nxt          = 1'b0;
    d_resp_nxt          = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d_c) begin
          // A simultaneous read and write is served as a store
          mem_write_nxt       = d_write;
          mem_read_nxt        = !d_write;
          mem_address_nxt     = d_address;
          mem_wdata_nxt       = d_wdata;
          mem_byte_enable_nxt = d_write ? d_wmask : 2'b00;
          if (i_read && (dcount != 3'd7)) dcount_nxt = dcount + 3'd1;
        end else if (grant_i_c) begin
          mem_read_nxt        = 1'b1;
          mem_write_nxt       = 1'b0;
          mem_address_nxt     = i_address;
          mem_byte_enable_nxt = 2'b00;
          dcount_nxt          = '0;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          i_rdata_nxt   = mem_rdata;
          i_resp_nxt    = 1'b1;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          if (mem_read) d_rdata_nxt = mem_rdata;
          d_resp_nxt    = 1'b1;
        end
      end
      default: begin
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, delayed response, read+write, starvation and reset abort.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read, d_read, d_write, mem_resp;
  logic [15:0] i_address, d_address, d_wdata, mem_rdata;
  logic [1:0]  d_wmask;
  logic [15:0] i_rdata, d_rdata, mem_address, mem_wdata;
  logic        i_resp, d_resp, mem_read, mem_write;
  logic [1:0]  mem_byte_enable;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] order_is_i;
    logic [2:0] exp_dcount [10];
    exp_dcount = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    order_is_i = 10'b10_0001_0000;

    rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; d_wmask = '0; mem_rdata = '0;
    step(); step();
    check("rst_mem_read",  16'(mem_read), 16'h0);
    check("rst_mem_write", 16'(mem_write), 16'h0);
    check("rst_resp",      16'({i_resp, d_resp}), 16'h0);
    check("rst_rdata",     i_rdata | d_rdata, 16'h0);
    check("rst_addr",      mem_address | mem_wdata, 16'h0);
    rst_n = 1'b1;

    // Instruction fetch with one-cycle memory latency; request dropped during service
    i_read = 1'b1; i_address = 16'h0040;
    step();
    check("if_mem_read", 16'(mem_read), 16'h1);
    check("if_mem_write", 16'(mem_write), 16'h0);
    check("if_mem_addr", mem_address, 16'h0040);
    check("if_be", 16'(mem_byte_enable), 16'h0);
    i_read = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h1234;
    step();
    check("if_i_resp", 16'(i_resp), 16'h1);
    check("if_d_resp", 16'(d_resp), 16'h0);
    check("if_i_rdata", i_rdata, 16'h1234);
    check("if_done_mem_read", 16'(mem_read), 16'h0);
    // Stray mem_resp in DONE and IDLE must be ignored
    mem_rdata = 16'hFFFF;
    step();
    check("if_i_resp_drop", 16'(i_resp), 16'h0);
    step();
    check("stray_state", 16'(dut.state), 16'h0);
    check("stray_i_rdata", i_rdata, 16'h1234);
    check("stray_mem_read", 16'(mem_read), 16'h0);
    mem_resp = 1'b0;

    // Masked store
    d_write = 1'b1; d_address = 16'h0100; d_wdata = 16'hBEEF; d_wmask = 2'b01;
    step();
    check("st_mem_write", 16'(mem_write), 16'h1);
    check("st_mem_read", 16'(mem_read), 16'h0);
    check("st_be", 16'(mem_byte_enable), 16'h1);
    check("st_wdata", mem_wdata, 16'hBEEF);
    check("st_addr", mem_address, 16'h0100);
    d_write = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h5555;
    step();
    check("st_d_resp", 16'(d_resp), 16'h1);
    check("st_i_resp", 16'(i_resp), 16'h0);
    check("st_d_rdata", d_rdata, 16'h0000);
    mem_resp = 1'b0;
    step();
    check("st_d_resp_drop", 16'(d_resp), 16'h0);

    // Load with a five-cycle memory delay
    d_read = 1'b1; d_address = 16'h0200;
    step();
    d_read = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("dly_mem_read", 16'(mem_read), 16'h1);
      check("dly_mem_addr", mem_address, 16'h0200);
      check("dly_d_resp", 16'(d_resp), 16'h0);
      step();
    end
    // mem_resp arrives in the sixth service cycle
    mem_resp = 1'b1; mem_rdata = 16'hA5A5;
    check("dly_last_mem_read", 16'(mem_read), 16'h1);
    step();
    check("dly_d_resp", 16'(d_resp), 16'h1);
    check("dly_d_rdata", d_rdata, 16'hA5A5);
    mem_resp = 1'b0;
    step();
    check("dly_resp_single", 16'(d_resp), 16'h0);
    step();
    check("dly_no_relaunch", 16'({mem_read, mem_write, d_resp}), 16'h0);

    // Read and write together are a store
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0300; d_wdata = 16'h1111; d_wmask = 2'b11;
    step();
    check("rw_mem_write", 16'(mem_write), 16'h1);
    check("rw_mem_read", 16'(mem_read), 16'h0);
    check("rw_be", 16'(mem_byte_enable), 16'h3);
    d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h7777;
    step();
    check("rw_d_resp", 16'(d_resp), 16'h1);
    check("rw_d_rdata", d_rdata, 16'hA5A5);
    mem_resp = 1'b0;
    step();

    // Starvation: both ports held, expected D,D,D,D,I,D,D,D,D,I
    i_read = 1'b1; i_address = 16'h0400; d_read = 1'b1; d_address = 16'h0500;
    for (int g = 0; g < 10; g++) begin
      step();
      check($sformatf("starve_grant%0d", g), mem_address, order_is_i[g] ? 16'h0400 : 16'h0500);
      mem_resp = 1'b1; mem_rdata = 16'h1000 + 16'(g);
      step();
      check($sformatf("starve_resp%0d", g), 16'({i_resp, d_resp}), order_is_i[g] ? 16'h2 : 16'h1);
      mem_resp = 1'b0;
      step();
      check($sformatf("starve_dcount%0d", g), 16'(dut.dcount), 16'(exp_dcount[g]));
    end
    check("starve_i_rdata", i_rdata, 16'h1009);
    check("starve_d_rdata", d_rdata, 16'h1008);
    i_read = 1'b0; d_read = 1'b0;
    step();

    // Reset while serving a load abandons it
    d_read = 1'b1; d_address = 16'h0600;
    step();
    check("rs_serving", 16'(mem_read), 16'h1);
    d_read = 1'b0; rst_n = 1'b0;
    step();
    check("rs_mem_read", 16'(mem_read), 16'h0);
    check("rs_d_rdata", d_rdata, 16'h0000);
    check("rs_state", 16'(dut.state), 16'h0);
    rst_n = 1'b1; mem_resp = 1'b1; mem_rdata = 16'h9999;
    step();
    check("rs_no_resp", 16'({i_resp, d_resp}), 16'h0);
    check("rs_mem_read_late", 16'(mem_read), 16'h0);
    check("rs_d_rdata_late", d_rdata, 16'h0000);
    check("rs_state_late", 16'(dut.state), 16'h0);
    mem_resp = 1'b0;
    step();
    check("rs_no_resp_after", 16'({i_resp, d_resp}), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive D grants allowed while i_read is pending before I is forced.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 i_read  input  1  instruction-fetch request from datapath.
REQ-005 i_address  input  16  fetch address.
REQ-006 i_rdata  output  16  fetched instruction; registered.
REQ-007 i_resp  output  1  one-cycle completion pulse for fetch.
REQ-008 d_read / d_write  input  1 each  data load / store request.
REQ-009 d_address  input  16;  d_wdata  input  16;  d_wmask  input  2  store byte mask.
REQ-010 d_rdata  output  16  load data; registered.
REQ-011 d_resp  output  1  one-cycle completion pulse for load/store.
REQ-012 mem_read / mem_write  output  1 each  request to shared memory.
REQ-013 mem_address  output  16;  mem_wdata  output  16;  mem_byte_enable  output  2.
REQ-014 mem_rdata  input  16;  mem_resp  input  1  memory completion, sampled only while serving.

Function
REQ-015 FSM SHALL have states IDLE, SERVE_I, SERVE_D, DONE; all outputs SHALL be registered.
REQ-016 IDLE: if (d_read|d_write) and (!i_read or dcount < STARVE_LIMIT) -> SERVE_D; else if i_read -> SERVE_I; else stay.
REQ-017 On grant, address/wdata/mask/direction SHALL be latched; mem_* SHALL assert on the edge entering SERVE_x (one cycle after request sampled in IDLE).
REQ-018 SERVE_I: mem_read=1, mem_write=0, mem_byte_enable=2'b00, mem_address=latched i_address.
REQ-019 SERVE_D load: mem_read=1, mem_byte_enable=2'b00; store: mem_write=1, mem_wdata=latched d_wdata, mem_byte_enable=latched d_wmask.
REQ-020 d_read and d_write both high SHALL be treated as a store.
REQ-021 SERVE_x holds mem_* stable until mem_resp=1; on that edge mem_read/mem_write SHALL drop, mem_rdata SHALL be captured (reads only), state -> DONE.
REQ-022 DONE: exactly one of i_resp/d_resp = 1 for one cycle, matching the served port; mem_read=mem_write=0; next state IDLE unconditionally.
REQ-023 i_rdata/d_rdata SHALL hold their last captured value until the next read completion on that port; stores SHALL NOT modify d_rdata.
REQ-024 Minimum transaction: request in IDLE cycle N, mem_resp in cycle N+1 -> resp pulse in N+2, IDLE in N+3; back-to-back grants SHALL be ≥3 cycles apart.
REQ-025 dcount (3 bits, saturating at 7): +1 on each D grant while i_read=1; cleared on every I grant; unchanged on D grant with i_read=0.
REQ-026 A request deasserted during SERVE_x SHALL NOT abort; transaction completes and resp pulse is still issued.
REQ-027 mem_resp in IDLE or DONE SHALL be ignored (no state, data, or dcount change).
REQ-028 A request still asserted during DONE SHALL be treated as a new request in the following IDLE.

Reset
REQ-029 When rst_n=0 at a rising edge: state=IDLE, dcount=0, all outputs 0 (including i_rdata, d_rdata, mem_address, mem_wdata) after that edge.
REQ-030 Reset during SERVE_x SHALL abandon the transaction; no resp pulse; a later mem_resp SHALL be ignored per REQ-027.

Verification
REQ-031 i_read=1, i_address=16'h0040, mem_resp 1 cycle after mem_read with mem_rdata=16'h1234 -> i_resp pulse one cycle, i_rdata=16'h1234, d_resp=0.
REQ-032 d_write=1, d_address=16'h0100, d_wdata=16'hBEEF, d_wmask=2'b01 -> mem_write=1, mem_byte_enable=2'b01, mem_wdata=16'hBEEF; d_resp pulse; d_rdata unchanged.
REQ-033 i_read and d_read held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; dcount returns to 0 after each I.
REQ-034 mem_resp delayed 5 cycles -> mem_read/mem_address stable all 5 cycles; single resp pulse; no second transaction launched.
REQ-035 rst_n=0 for one edge while in SERVE_D, then mem_resp=1 -> no d_resp, mem_read=0, state IDLE, d_rdata=16'h0000.
REQ-036 d_read and d_write both 1 -> mem_write=1, mem_read=0; d_rdata unchanged on completion.
